// File: rtl/conf_status_tx_channel.sv
// RIFFA TX channel that returns a fixed status/acknowledge packet to the host.
// Define CONF_TX_SEQ_EN to append a sequence beat {~seq, seq} (LEN becomes 6).
module conf_status_tx_channel #(
  parameter int          C_PCI_DATA_WIDTH = 64,
  parameter logic [31:0] C_MAGIC          = 32'h02020202
) (
  input  logic                        CLK,
  input  logic                        RST,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN,
  input  logic                        SEND,
  input  logic [31:0]                 WIDTH,
  input  logic [31:0]                 HEIGHT,
  input  logic [31:0]                 STATUS,
  output logic                        BUSY,
  output logic                        SEND_DONE
);

`ifdef CONF_TX_SEQ_EN
  localparam int NBEATS = 3;
`else
  localparam int NBEATS = 2;
`endif
  localparam logic [1:0]  LAST_BEAT = 2'(NBEATS - 1);
  localparam logic [31:0] PKT_LEN   = 32'(NBEATS * 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  state_t                        r_state;
  logic                          r_pending;
  logic [1:0]                    r_beat_cnt;
  logic [31:0]                   r_width;
  logic [31:0]                   r_height;
  logic [31:0]                   r_status;
  logic                          r_tx;
  logic                          r_valid;
  logic                          r_done;
  logic                          r_busy;
  logic [C_PCI_DATA_WIDTH-1:0]   r_data;
`ifdef CONF_TX_SEQ_EN
  logic [31:0]                   r_seq;
`endif

  logic [1:0]                    w_next_idx;
  logic [C_PCI_DATA_WIDTH-1:0]   w_next_beat;
  logic                          w_accept;
  logic                          w_last;

  assign w_next_idx = r_beat_cnt + 2'd1;
  assign w_accept   = r_valid & CHNL_TX_DATA_REN;
  assign w_last     = (r_beat_cnt == LAST_BEAT);

  // Beat 0 is loaded on ACK; this mux supplies the beats that follow it.
  always_comb begin
    w_next_beat = '0;
    unique case (w_next_idx)
      2'd1:    w_next_beat = {r_status, r_height};
`ifdef CONF_TX_SEQ_EN
      2'd2:    w_next_beat = {~r_seq, r_seq};
`endif
      default: w_next_beat = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_beat_cnt <= 2'd0;
      r_width    <= '0;
      r_height   <= '0;
      r_status   <= '0;
      r_tx       <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_data     <= '0;
`ifdef CONF_TX_SEQ_EN
      r_seq      <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (SEND) begin
            r_width  <= WIDTH;
            r_height <= HEIGHT;
            r_status <= STATUS;
            r_tx     <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (SEND) r_pending <= 1'b1;
          if (CHNL_TX_ACK) begin
            r_valid    <= 1'b1;
            r_data     <= {r_width, C_MAGIC};
            r_beat_cnt <= 2'd0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (SEND) r_pending <= 1'b1;
          if (w_accept) begin
            if (w_last) begin
              r_tx    <= 1'b0;
              r_valid <= 1'b0;
              r_data  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_beat_cnt <= w_next_idx;
              r_data     <= w_next_beat;
            end
          end
        end
        S_DONE: begin
`ifdef CONF_TX_SEQ_EN
          r_seq <= r_seq + 32'd1;
`endif
          // A SEND landing in this cycle is merged like a pending one.
          if (r_pending || SEND) begin
            r_width   <= WIDTH;
            r_height  <= HEIGHT;
            r_status  <= STATUS;
            r_pending <= 1'b0;
            r_tx      <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CHNL_TX_CLK        = CLK;
  assign CHNL_TX            = r_tx;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_LEN        = PKT_LEN;
  assign CHNL_TX_OFF        = '0;
  assign CHNL_TX_DATA       = r_data;
  assign CHNL_TX_DATA_VALID = r_valid;
  assign BUSY               = r_busy;
  assign SEND_DONE          = r_done;

endmodule

// File: tb/tb_conf_status_tx_channel.sv
// Bench for conf_status_tx_channel: randomized packets vs a packet-level model.
// Honours CONF_TX_SEQ_EN the same way as the design.
module tb_conf_status_tx_channel;

  localparam logic [31:0] MAGIC = 32'h02020202;
`ifdef CONF_TX_SEQ_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_clk;
  logic        tx;
  logic        ack;
  logic        tx_last;
  logic [31:0] tx_len;
  logic [30:0] tx_off;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        ren;
  logic        send;
  logic [31:0] width;
  logic [31:0] height;
  logic [31:0] status;
  logic        busy;
  logic        send_done;

  conf_status_tx_channel dut (
    .CLK                (clk),
    .RST                (rst),
    .CHNL_TX_CLK        (tx_clk),
    .CHNL_TX            (tx),
    .CHNL_TX_ACK        (ack),
    .CHNL_TX_LAST       (tx_last),
    .CHNL_TX_LEN        (tx_len),
    .CHNL_TX_OFF        (tx_off),
    .CHNL_TX_DATA       (tx_data),
    .CHNL_TX_DATA_VALID (tx_valid),
    .CHNL_TX_DATA_REN   (ren),
    .SEND               (send),
    .WIDTH              (width),
    .HEIGHT             (height),
    .STATUS             (status),
    .BUSY               (busy),
    .SEND_DONE          (send_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] got[$];
  logic [63:0] exp_q[$];
  int          done_cnt;
  int          stall_chg;
  logic        ack_valid;
  logic        done_after;
  logic [31:0] len_seen;
  int unsigned pkts_done = 0;

  // Packet model: beats derived directly from the reported values.
  function automatic void build_exp(input logic [31:0] w, input logic [31:0] h,
                                    input logic [31:0] s, input int unsigned sq);
    logic [31:0] sv;
    sv = sq;
    exp_q.delete();
    exp_q.push_back({w, MAGIC});
    exp_q.push_back({s, h});
    if (NB == 3) exp_q.push_back({~sv, sv});
  endfunction

  task automatic do_send(input logic [31:0] w, input logic [31:0] h, input logic [31:0] s);
    width = w; height = h; status = s; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Acts as the host for one packet; records accepted beats, no checking.
  task automatic drive_pkt(input int ack_dly, input int mode);
    int   n;
    bit   tog;
    bit   have_prev;
    logic [63:0] prev;
    logic r;
    got.delete();
    done_cnt = 0; stall_chg = 0; ack_valid = 1'b0; done_after = 1'b1;
    len_seen = '0;
    n = 0;
    while (!tx && n < 20) begin @(negedge clk); n++; end
    if (!tx) return;
    len_seen = tx_len;
    repeat (ack_dly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    ack_valid = tx_valid;
    n = 0; tog = 1'b1; have_prev = 1'b0; prev = '0;
    while (n < 200) begin
      if (send_done) begin done_cnt++; break; end
      if (tx_valid) begin
        if (have_prev && tx_data !== prev) stall_chg++;
        r = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
        tog = ~tog;
        ren = r;
        if (r) begin got.push_back(tx_data); have_prev = 1'b0; end
        else begin prev = tx_data; have_prev = 1'b1; end
      end else begin
        ren = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      n++;
    end
    ren = 1'b0;
    @(negedge clk);
    done_after = send_done;
    if (done_cnt == 1) pkts_done++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b0; ren = 1'b0; send = 1'b0;
    width = '0; height = '0; status = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx, tx_valid, send_done, busy, tx_data} !== 68'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got tx=%b v=%b done=%b busy=%b data=%h, want all 0",
               tx, tx_valid, send_done, busy, tx_data);
    end
    vectors++;
    if (tx_last !== 1'b1 || tx_off !== 31'd0 || tx_len !== 32'(NB * 2)) begin
      miscompares++;
      $display("FAIL reset_consts: last=%b off=%0d len=%0d, want 1/0/%0d",
               tx_last, tx_off, tx_len, NB * 2);
    end
    rst = 1'b0;
    pkts_done = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    build_exp(32'd1920, 32'd1080, 32'd5, pkts_done);
    width = 32'd1920; height = 32'd1080; status = 32'd5; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL send_latency: tx=%b busy=%b, want 1/1", tx, busy);
    end
    drive_pkt(3, 0);
    vectors++;
    if (len_seen !== 32'(NB * 2)) begin
      miscompares++;
      $display("FAIL basic_len: got %0d want %0d", len_seen, NB * 2);
    end
    vectors++;
    if (ack_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_latency: valid=%b want 1", ack_valid);
    end
    vectors++;
    if (got.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d beats want %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_after !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done: pulses=%0d after=%b busy=%b want 1/0/0",
               done_cnt, done_after, busy);
    end
  endtask

  task automatic test_ren_toggle();
    logic [31:0] w, h, s;
    w = $urandom; h = $urandom; s = $urandom;
    build_exp(w, h, s, pkts_done);
    do_send(w, h, s);
    drive_pkt(1, 1);
    vectors++;
    if (stall_chg != 0) begin
      miscompares++;
      $display("FAIL toggle_stable: %0d changes while stalled, want 0", stall_chg);
    end
    vectors++;
    if (got.size() != exp_q.size() || done_cnt != 1) begin
      miscompares++;
      $display("FAIL toggle_count: beats=%0d done=%0d want %0d/1",
               got.size(), done_cnt, exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL toggle_beat%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_pending();
    logic [31:0] s;
    int extra;
    s = $urandom;
    build_exp(32'd800, 32'd600, s, pkts_done);
    do_send(32'd800, 32'd600, s);
    fork
      drive_pkt(2, 0);
      begin
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        width = 32'd640; height = 32'd480; send = 1'b1;
        repeat (3) @(negedge clk);
        send = 1'b0;
      end
    join
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL pend_first_beat%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
      end
    end
    build_exp(32'd640, 32'd480, s, pkts_done);
    drive_pkt(0, 0);
    vectors++;
    if (got.size() != exp_q.size() || done_cnt != 1) begin
      miscompares++;
      $display("FAIL pend_second_count: beats=%0d done=%0d want %0d/1",
               got.size(), done_cnt, exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL pend_second_beat%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
      end
    end
    extra = 0;
    repeat (10) begin
      if (tx || send_done || busy) extra++;
      @(negedge clk);
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL pend_no_third: %0d busy cycles after merged packet, want 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] w, h, s;
    int n;
    do_send($urandom, $urandom, $urandom);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n = 0;
    while (!tx_valid && n < 10) begin @(negedge clk); n++; end
    ren = 1'b1;
    @(negedge clk);
    ren = 1'b0; rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({tx, tx_valid, send_done, busy, tx_data} !== 68'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: tx=%b v=%b done=%b busy=%b data=%h, want all 0",
               tx, tx_valid, send_done, busy, tx_data);
    end
    rst = 1'b0;
    pkts_done = 0;
    @(negedge clk);
    vectors++;
    if (send_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_quiet: done=%b busy=%b want 0/0", send_done, busy);
    end
    w = $urandom; h = $urandom; s = $urandom;
    build_exp(w, h, s, pkts_done);
    do_send(w, h, s);
    drive_pkt(1, 0);
    vectors++;
    if (got.size() != exp_q.size() || done_cnt != 1) begin
      miscompares++;
      $display("FAIL midreset_count: beats=%0d done=%0d want %0d/1",
               got.size(), done_cnt, exp_q.size());
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midreset_beat%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] w, h, s;
    int bad;
    bad = 0;
    ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (tx || busy || tx_valid) bad++;
    end
    ack = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ack_idle: %0d cycles left idle, want 0", bad);
    end
    w = $urandom; h = $urandom; s = $urandom;
    build_exp(w, h, s, pkts_done);
    do_send(w, h, s);
    ren = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!tx || !busy || tx_valid) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ren_in_req: %0d cycles off REQ, want 0", bad);
    end
    drive_pkt(0, 0);
    foreach (exp_q[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL ignored_beat%0d: got %h want %h", i,
                 (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w, h, s;
    for (int k = 0; k < 8; k++) begin
      w = $urandom; h = $urandom; s = $urandom;
      build_exp(w, h, s, pkts_done);
      do_send(w, h, s);
      width = $urandom; height = $urandom; status = $urandom;
      drive_pkt(int'($urandom_range(0, 4)), 2);
      vectors++;
      if (got.size() != exp_q.size() || done_cnt != 1 || stall_chg != 0 ||
          len_seen !== 32'(NB * 2)) begin
        miscompares++;
        $display("FAIL rand%0d_shape: beats=%0d done=%0d chg=%0d len=%0d want %0d/1/0/%0d",
                 k, got.size(), done_cnt, stall_chg, len_seen, exp_q.size(), NB * 2);
      end
      foreach (exp_q[i]) begin
        vectors++;
        if (i >= got.size() || got[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rand%0d_beat%0d: got %h want %h", k, i,
                   (i < got.size()) ? got[i] : 64'hx, exp_q[i]);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ren_toggle();
    test_pending();
    test_mid_reset();
    test_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want normal end");
    $fatal(1, "timeout");
  end

endmodule
